// File: rtl/led_step_ctrl.sv
// led_step_ctrl
//   Control front end for the LED shifter. Three push buttons (speed,
//   direction, pause) are synchronized and debounced. Their press events
//   drive the step prescaler and the direction and run flags that the
//   shifter consumes.
//
// Ports
//   clk_50M    in   system clock (single clock domain)
//   reset      in   synchronous, active-high
//   btn_speed  in   async button: each press advances speed_idx (mod 4)
//   btn_dir    in   async button: each press toggles dir
//   btn_pause  in   async button: each press toggles running
//   step_tick  out  one-cycle step enable, every P clocks while running
//   dir        out  0 = shift left, 1 = shift right
//   running    out  1 = stepping enabled
//   speed_idx  out  [1:0] speed index, P = BASE_DIV >> speed_idx
//
// Parameters
//   DB_CYCLES  debounce stability window in clocks (>= 2)
//   BASE_DIV   step period at speed index 0 (multiple of 8, >= 16)

// ---------------------------------------------------------------------------
// Per-button synchronizer + debouncer.
//   btn    in   raw asynchronous button level
//   press  out  high in the cycle whose edge moves 'stable' from 0 to 1
// ---------------------------------------------------------------------------
module led_step_db #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk_50M,
    input  logic reset,
    input  logic btn,
    output logic press
);
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          s1_q;
    logic          s2_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The counter only runs while the synchronized level disagrees with
    // 'stable'; any agreeing cycle clears it, so glitches shorter than the
    // window never reach 'stable'.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        press    = 1'b0;
        if (s2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = s2_q;
                // Acted on at the same edge 'stable' rises; releases are ignored.
                press    = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            s1_q     <= btn;
            s2_q     <= s1_q;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end
endmodule

// ---------------------------------------------------------------------------
// Top level
// ---------------------------------------------------------------------------
module led_step_ctrl #(
    parameter int DB_CYCLES = 1_000_000,
    parameter int BASE_DIV  = 25_000_000
) (
    input  logic       clk_50M,
    input  logic       reset,
    input  logic       btn_speed,
    input  logic       btn_dir,
    input  logic       btn_pause,
    output logic       step_tick,
    output logic       dir,
    output logic       running,
    output logic [1:0] speed_idx
);
    localparam int NUM_BTN   = 3;
    localparam int BTN_SPEED = 0;
    localparam int BTN_DIR   = 1;
    localparam int BTN_PAUSE = 2;

    // Prescaler width: BASE_DIV-1 is the largest count ever held.
    localparam int PW = $clog2(BASE_DIV);
    localparam logic [PW-1:0] TC0 = PW'((BASE_DIV >> 0) - 1);
    localparam logic [PW-1:0] TC1 = PW'((BASE_DIV >> 1) - 1);
    localparam logic [PW-1:0] TC2 = PW'((BASE_DIV >> 2) - 1);
    localparam logic [PW-1:0] TC3 = PW'((BASE_DIV >> 3) - 1);

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] press;

    assign btn_raw = {btn_pause, btn_dir, btn_speed};

    generate
        for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
            led_step_db #(
                .DB_CYCLES (DB_CYCLES)
            ) u_db (
                .clk_50M (clk_50M),
                .reset   (reset),
                .btn     (btn_raw[i]),
                .press   (press[i])
            );
        end
    endgenerate

    logic [PW-1:0] pre_cnt_q, pre_cnt_d;
    logic [PW-1:0] tc_val;
    logic          step_tick_q, step_tick_d;
    logic          dir_q, dir_d;
    logic          running_q, running_d;
    logic [1:0]    speed_idx_q, speed_idx_d;

    always_comb begin
        case (speed_idx_q)
            2'd0:    tc_val = TC0;
            2'd1:    tc_val = TC1;
            2'd2:    tc_val = TC2;
            default: tc_val = TC3;
        endcase

        running_d   = running_q ^ press[BTN_PAUSE];
        dir_d       = dir_q ^ press[BTN_DIR];
        // 2-bit add wraps 3 -> 0 on its own.
        speed_idx_d = speed_idx_q + {1'b0, press[BTN_SPEED]};
        step_tick_d = 1'b0;
        pre_cnt_d   = pre_cnt_q;

        // A speed change restarts the period and beats a coinciding terminal
        // count. Counting follows the post-toggle run flag: a pause that lands
        // on the terminal count freezes the prescaler at P-1, so the held tick
        // is delivered on the resume edge.
        if (press[BTN_SPEED]) begin
            pre_cnt_d = '0;
        end else if (running_d) begin
            if (pre_cnt_q == tc_val) begin
                pre_cnt_d   = '0;
                step_tick_d = 1'b1;
            end else begin
                pre_cnt_d = pre_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            pre_cnt_q   <= '0;
            step_tick_q <= 1'b0;
            dir_q       <= 1'b0;
            running_q   <= 1'b1;
            speed_idx_q <= 2'd0;
        end else begin
            pre_cnt_q   <= pre_cnt_d;
            step_tick_q <= step_tick_d;
            dir_q       <= dir_d;
            running_q   <= running_d;
            speed_idx_q <= speed_idx_d;
        end
    end

    assign step_tick = step_tick_q;
    assign dir       = dir_q;
    assign running   = running_q;
    assign speed_idx = speed_idx_q;
endmodule

// File: tb/tb_led_step_ctrl.sv
// Testbench for led_step_ctrl with DB_CYCLES = 4 and BASE_DIV = 16.
// A reference model turns each clock's inputs into the expected outputs and
// queues them; a monitor pops one entry per cycle and compares it with the DUT.
module tb_led_step_ctrl;
    localparam int DB   = 4;
    localparam int BASE = 16;

    logic       clk_50M = 1'b0;
    logic       reset;
    logic       btn_speed, btn_dir, btn_pause;
    logic       step_tick, dir, running;
    logic [1:0] speed_idx;

    led_step_ctrl #(
        .DB_CYCLES (DB),
        .BASE_DIV  (BASE)
    ) dut (
        .clk_50M   (clk_50M),
        .reset     (reset),
        .btn_speed (btn_speed),
        .btn_dir   (btn_dir),
        .btn_pause (btn_pause),
        .step_tick (step_tick),
        .dir       (dir),
        .running   (running),
        .speed_idx (speed_idx)
    );

    always #10 clk_50M = ~clk_50M;

    typedef struct packed {
        logic       tick;
        logic       dir;
        logic       run;
        logic [1:0] spd;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc_no = 0;

    // ---------------- reference model ----------------
    // A button's debounced level flips once the synchronized input (two
    // clocks behind the pin) has disagreed with it for DB consecutive clocks.
    // m_hist bit k holds the pin value sampled k+1 edges ago.
    logic [7:0] m_hist [3];
    logic [2:0] m_stable;
    logic [2:0] m_ev;
    logic [2:0] m_raw;
    logic       m_dir, m_run, m_tick;
    int         m_spd, m_rem;
    exp_t       m_e;

    initial begin
        for (int i = 0; i < 3; i++) m_hist[i] = '0;
        m_stable = '0;
        m_dir = 1'b0; m_run = 1'b1; m_spd = 0; m_rem = BASE;
        forever begin
            @(posedge clk_50M);
            cyc_no++;
            if (reset) begin
                for (int i = 0; i < 3; i++) m_hist[i] = '0;
                m_stable = '0;
                m_dir = 1'b0; m_run = 1'b1; m_spd = 0; m_rem = BASE;
                m_tick = 1'b0;
            end else begin
                m_raw = {btn_pause, btn_dir, btn_speed};
                m_ev  = '0;
                for (int i = 0; i < 3; i++) begin
                    if (!m_stable[i] && (&m_hist[i][DB:1])) begin
                        m_stable[i] = 1'b1;
                        m_ev[i]     = 1'b1;
                    end else if (m_stable[i] && !(|m_hist[i][DB:1])) begin
                        m_stable[i] = 1'b0;
                    end
                    m_hist[i] = {m_hist[i][6:0], m_raw[i]};
                end
                m_run  = m_run ^ m_ev[2];
                m_dir  = m_dir ^ m_ev[1];
                m_tick = 1'b0;
                // m_rem: counting clocks left until the next tick.
                if (m_ev[0]) begin
                    m_spd = (m_spd + 1) % 4;
                    m_rem = BASE >> m_spd;
                end else if (m_run) begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_tick = 1'b1;
                        m_rem  = BASE >> m_spd;
                    end
                end
            end
            m_e.tick = m_tick;
            m_e.dir  = m_dir;
            m_e.run  = m_run;
            m_e.spd  = 2'(m_spd);
            exp_q.push_back(m_e);
        end
    end

    // ---------------- monitor ----------------
    exp_t e, act;
    initial begin
        forever begin
            @(negedge clk_50M);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {step_tick, dir, running, speed_idx};
                n_cmp++;
                if (act !== e) begin
                    n_err++;
                    if (n_err <= 20)
                        $display("FAIL outputs cycle %0d: got tick=%b dir=%b run=%b spd=%0d, want tick=%b dir=%b run=%b spd=%0d",
                                 cyc_no, act.tick, act.dir, act.run, act.spd,
                                 e.tick, e.dir, e.run, e.spd);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk_50M);
    endtask

    task automatic press_speed(input int len, input int gap);
        btn_speed = 1'b1; cyc(len); btn_speed = 1'b0; cyc(gap);
    endtask

    int glitch[3] = '{1, 2, 3};
    int hold[3];

    initial begin
        reset = 1'b1; btn_speed = 1'b0; btn_dir = 1'b0; btn_pause = 1'b0;
        cyc(3);
        reset = 1'b0;
        // idle ticking at speed 0
        cyc(60);
        // five speed presses: 1, 2, 3, 0, 1
        repeat (5) press_speed(10, 50);
        // short direction glitches, then a real press
        for (int i = 0; i < 3; i++) begin
            btn_dir = 1'b1; cyc(glitch[i]); btn_dir = 1'b0; cyc(12);
        end
        btn_dir = 1'b1; cyc(6); btn_dir = 1'b0; cyc(30);
        // back to speed 0, then pause / resume
        repeat (3) press_speed(10, 40);
        btn_pause = 1'b1; cyc(6); btn_pause = 1'b0; cyc(40);
        btn_pause = 1'b1; cyc(6); btn_pause = 1'b0; cyc(60);
        // simultaneous presses
        btn_speed = 1'b1; btn_dir = 1'b1; btn_pause = 1'b1; cyc(8);
        btn_speed = 1'b0; btn_dir = 1'b0; btn_pause = 1'b0; cyc(30);
        btn_pause = 1'b1; cyc(8); btn_pause = 1'b0; cyc(30);
        // reset mid-period with btn_dir held through it
        btn_dir = 1'b1; cyc(13);
        reset = 1'b1; cyc(1); reset = 1'b0;
        cyc(40); btn_dir = 1'b0; cyc(20);
        // randomized button activity with occasional resets
        for (int i = 0; i < 3; i++) hold[i] = $urandom_range(1, 9);
        for (int c = 0; c < 5000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (hold[i] == 0) begin
                    case (i)
                        0: btn_speed = ~btn_speed;
                        1: btn_dir   = ~btn_dir;
                        default: btn_pause = ~btn_pause;
                    endcase
                    hold[i] = $urandom_range(1, 9);
                end else begin
                    hold[i]--;
                end
            end
            reset = ($urandom_range(0, 599) == 0);
            cyc(1);
        end
        reset = 1'b0; btn_speed = 1'b0; btn_dir = 1'b0; btn_pause = 1'b0;
        cyc(40);
        if (n_cmp < 12) begin
            n_err++;
            $display("FAIL compare_count: got %0d, want at least 12", n_cmp);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
